instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: HOLD_CYCLES, default 2, clock cycles each instruction word is held on instruct (legal range 1..15).
REQ-002 Port: clock  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: resetN  input  1  asynchronous, active-low reset.
REQ-004 Port: loadEn  input  1  payload buffer write strobe.
REQ-005 Port: loadAddr  input  2  payload buffer index; index 0 = least-significant word.
REQ-006 Port: loadData  input  32  payload word to store.
REQ-007 Port: cmdValid  input  1  host requests issue of one command.
REQ-008 Port: cmdOpcode  input  5  command opcode placed in header bits [4:0].
REQ-009 Port: cmdLen  input  3  number of payload words following the header (0..4).
REQ-010 Port: cmdReady  output  1  sequencer can accept a command.
REQ-011 Port: instruct  output  32  instruction word stream to the controller.
REQ-012 Port: busy  output  1  command in progress.
REQ-013 Port: done  output  1  one-cycle pulse at command completion.

Function
REQ-014 The block SHALL hold a 4 x 32-bit payload buffer written on a rising edge when loadEn=1 and state is IDLE; writes while not IDLE SHALL be ignored.
REQ-015 The block SHALL implement states IDLE, HEADER, PAYLOAD, GAP.
REQ-016 cmdReady SHALL be 1 only in IDLE; busy SHALL be 1 in HEADER, PAYLOAD, GAP.
REQ-017 A command SHALL be accepted on a rising edge where cmdValid=1 and cmdReady=1; opcode and effective length SHALL be latched at that edge.
REQ-018 Effective length SHALL be min(cmdLen, 4); values 5..7 SHALL be clamped to 4.
REQ-019 IDLE -> HEADER on acceptance; instruct SHALL equal {1'b1, 26'b0, opcode} starting the cycle after acceptance.
REQ-020 Each word (header and payload) SHALL be driven on instruct for exactly HOLD_CYCLES consecutive cycles.
REQ-021 HEADER -> PAYLOAD after HOLD_CYCLES if effective length > 0, else HEADER -> GAP.
REQ-022 PAYLOAD SHALL drive buffer[0], buffer[1], ... buffer[len-1] in ascending index order, each for HOLD_CYCLES, then transition to GAP.
REQ-023 GAP SHALL last exactly one cycle with instruct=0 and done=1, then return to IDLE.
REQ-024 In IDLE, instruct SHALL be 32'h00000000 and done SHALL be 0.
REQ-025 Total occupancy from acceptance edge to return to IDLE SHALL be (1+len)*HOLD_CYCLES + 1 cycles.
REQ-026 cmdValid asserted while not IDLE SHALL have no effect; the host must hold it until accepted.
REQ-027 A load to the same index as, and on the same edge as, command acceptance SHALL be written before the command's payload is read (payload reflects the new value).
REQ-028 Hold and word-index counters SHALL wrap only under state control; no counter SHALL overflow for HOLD_CYCLES up to 15.
REQ-029 Payload buffer contents SHALL persist across commands until overwritten.

Reset
REQ-030 On resetN=0, state SHALL go to IDLE immediately, independent of clock: instruct=0, busy=0, done=0, cmdReady=1, counters=0.
REQ-031 Payload buffer SHALL clear to all zeros on reset.
REQ-032 Reset asserted mid-command SHALL abort the command with no further words and no done pulse; after release, the first rising edge with cmdValid=1 SHALL be accepted.

Verification
REQ-033 Load buffer[0..3] = e0318a99, 23f247b3, ed8ff212, ef0bc156; cmdOpcode=0, cmdLen=4, HOLD_CYCLES=2 -> instruct = 80000000 x2, e0318a99 x2, 23f247b3 x2, ed8ff212 x2, ef0bc156 x2, then 0 with done=1 for 1 cycle; busy high for 11 cycles.
REQ-034 cmdOpcode=7, cmdLen=0 -> instruct = 80000007 for 2 cycles, then 0 with done pulse; busy high for 3 cycles.
REQ-035 cmdLen=6 with buffer as in REQ-033 -> identical to the 4-word sequence (clamp); loadEn pulses during busy leave the buffer unchanged (checked on a following command).
REQ-036 Reset asserted during the second payload word -> instruct=0, busy=0, cmdReady=1 asynchronously; no done pulse; buffer reads as zeros on the next cmdLen=1 command (instruct 8000000x then 00000000).
REQ-037 Back-to-back: cmdValid held high across two commands -> second header starts exactly 2 cycles after the first command's done cycle (IDLE acceptance edge, then header); HOLD_CYCLES=1 run repeats REQ-033 with single-cycle words and 6-cycle occupancy.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: emits a header word followed by up to four buffered
// payload words, each held for HOLD_CYCLES, then a one-cycle done gap.
module instr_sequencer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        loadEn,
  input  logic [1:0]  loadAddr,
  input  logic [31:0] loadData,
  input  logic        cmdValid,
  input  logic [4:0]  cmdOpcode,
  input  logic [2:0]  cmdLen,
  output logic        cmdReady,
  output logic [31:0] instruct,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t      r_state,    w_state_nxt;
  logic [3:0]  r_hold_cnt, w_hold_nxt;
  logic [1:0]  r_word_idx, w_idx_nxt;
  logic [4:0]  r_opcode,   w_opcode_nxt;
  logic [2:0]  r_len,      w_len_nxt;
  logic [31:0] r_buf [4];

  logic [2:0]  w_len_eff;
  logic        w_hold_last;
  logic        w_last_word;
  logic        w_load_ok;

  assign w_len_eff   = (cmdLen > 3'd4) ? 3'd4 : cmdLen;
  assign w_hold_last = (r_hold_cnt == HOLD_LAST);
  assign w_last_word = ({1'b0, r_word_idx} == (r_len - 3'd1));
  assign w_load_ok   = loadEn && (r_state == IDLE);

  // A load on the acceptance edge lands before PAYLOAD can read it, so the
  // command always sees the freshly written word.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      // NOTE: the buffer is small and must read as zeros after reset, so it is
      // cleared here rather than left to a RAM without reset.
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else if (w_load_ok) begin
      r_buf[loadAddr] <= loadData;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_word_idx <= '0;
      r_opcode   <= '0;
      r_len      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_word_idx <= w_idx_nxt;
      r_opcode   <= w_opcode_nxt;
      r_len      <= w_len_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_idx_nxt    = r_word_idx;
    w_opcode_nxt = r_opcode;
    w_len_nxt    = r_len;
    cmdReady     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    instruct     = '0;

    unique case (r_state)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          w_state_nxt  = HEADER;
          w_hold_nxt   = '0;
          w_idx_nxt    = '0;
          w_opcode_nxt = cmdOpcode;
          w_len_nxt    = w_len_eff;
        end
      end
      HEADER: begin
        busy     = 1'b1;
        instruct = {1'b1, 26'b0, r_opcode};
        if (w_hold_last) begin
          w_hold_nxt  = '0;
          w_state_nxt = (r_len != 3'd0) ? PAYLOAD : GAP;
        end else begin
          w_hold_nxt = r_hold_cnt + 4'd1;
        end
      end
      PAYLOAD: begin
        busy     = 1'b1;
        instruct = r_buf[r_word_idx];
        if (w_hold_last) begin
          w_hold_nxt = '0;
          if (w_last_word) begin
            w_idx_nxt   = '0;
            w_state_nxt = GAP;
          end else begin
            w_idx_nxt = r_word_idx + 2'd1;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 4'd1;
        end
      end
      GAP: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: table of commands with expected word
// streams, plus hand sequences for reset abort, same-edge load and back-to-back.
module tb_instr_sequencer;

  typedef struct {
    logic [4:0]      opcode;
    logic [2:0]      len;
    int              n_words;
    logic [4:0][31:0] words;
  } cmd_vec_t;

  logic        clock = 1'b0;
  logic        resetN;
  logic        load_en0, load_en1;
  logic [1:0]  load_addr;
  logic [31:0] load_data;
  logic        cv0, cv1;
  logic [4:0]  opcode;
  logic [2:0]  len;
  logic        ready0, busy0, done0, ready1, busy1, done1;
  logic [31:0] instr0, instr1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  instr_sequencer #(.HOLD_CYCLES(2)) dut (
    .clock(clock), .resetN(resetN), .loadEn(load_en0), .loadAddr(load_addr),
    .loadData(load_data), .cmdValid(cv0), .cmdOpcode(opcode), .cmdLen(len),
    .cmdReady(ready0), .instruct(instr0), .busy(busy0), .done(done0)
  );

  instr_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clock(clock), .resetN(resetN), .loadEn(load_en1), .loadAddr(load_addr),
    .loadData(load_data), .cmdValid(cv1), .cmdOpcode(opcode), .cmdLen(len),
    .cmdReady(ready1), .instruct(instr1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [1:0] a, input logic [31:0] d);
    load_en0 = 1'b1; load_en1 = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en0 = 1'b0; load_en1 = 1'b0;
  endtask

  function automatic cmd_vec_t mk(input logic [4:0] op, input logic [2:0] l, input int n,
                                  input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input logic [31:0] w3,
                                  input logic [31:0] w4);
    cmd_vec_t v;
    v.opcode = op; v.len = l; v.n_words = n;
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3; v.words[4] = w4;
    return v;
  endfunction

  // Issue one command from IDLE and check every cycle until back in IDLE.
  task automatic run_cmd(input logic sel, input cmd_vec_t v, input int hold,
                         input logic busy_load, input logic same_load,
                         input logic [1:0] sl_addr, input logic [31:0] sl_data,
                         input string tag);
    opcode = v.opcode; len = v.len;
    if (sel) cv1 = 1'b1; else cv0 = 1'b1;
    if (same_load) begin
      load_en0 = 1'b1; load_en1 = 1'b1; load_addr = sl_addr; load_data = sl_data;
    end
    check({tag, " ready"}, 32'(sel ? ready1 : ready0), 32'd1);
    tick();
    cv0 = 1'b0; cv1 = 1'b0; load_en0 = 1'b0; load_en1 = 1'b0;
    for (int w = 0; w < v.n_words; w++) begin
      for (int h = 0; h < hold; h++) begin
        if (busy_load) begin
          load_en0 = 1'b1; load_addr = 2'(w + h); load_data = 32'hdeadbeef;
        end
        check($sformatf("%s w%0d h%0d instr", tag, w, h), sel ? instr1 : instr0, v.words[w]);
        check($sformatf("%s w%0d h%0d busy", tag, w, h), 32'(sel ? busy1 : busy0), 32'd1);
        check($sformatf("%s w%0d h%0d done", tag, w, h), 32'(sel ? done1 : done0), 32'd0);
        tick();
      end
    end
    check({tag, " gap instr"}, sel ? instr1 : instr0, 32'h0);
    check({tag, " gap done"}, 32'(sel ? done1 : done0), 32'd1);
    check({tag, " gap busy"}, 32'(sel ? busy1 : busy0), 32'd1);
    tick();
    load_en0 = 1'b0;
    check({tag, " idle busy"}, 32'(sel ? busy1 : busy0), 32'd0);
    check({tag, " idle ready"}, 32'(sel ? ready1 : ready0), 32'd1);
    check({tag, " idle instr"}, sel ? instr1 : instr0, 32'h0);
    check({tag, " idle done"}, 32'(sel ? done1 : done0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cmd_vec_t vecs [5];
    vecs[0] = mk(5'd0, 3'd4, 5, 32'h80000000, 32'he0318a99, 32'h23f247b3, 32'hed8ff212, 32'hef0bc156);
    vecs[1] = mk(5'd7, 3'd0, 1, 32'h80000007, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[2] = mk(5'h1f, 3'd6, 5, 32'h8000001f, 32'he0318a99, 32'h23f247b3, 32'hed8ff212, 32'hef0bc156);
    vecs[3] = mk(5'd3, 3'd2, 3, 32'h80000003, 32'he0318a99, 32'h23f247b3, 32'h0, 32'h0);
    vecs[4] = mk(5'd5, 3'd7, 5, 32'h80000005, 32'he0318a99, 32'h23f247b3, 32'hed8ff212, 32'hef0bc156);

    resetN = 1'b0; load_en0 = 1'b0; load_en1 = 1'b0; load_addr = '0; load_data = '0;
    cv0 = 1'b0; cv1 = 1'b0; opcode = '0; len = '0;
    #12;
    check("reset instr", instr0, 32'h0);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset done", 32'(done0), 32'd0);
    check("reset ready", 32'(ready0), 32'd1);
    @(negedge clock);
    resetN = 1'b1;
    tick();

    load_word(2'd0, 32'he0318a99);
    load_word(2'd1, 32'h23f247b3);
    load_word(2'd2, 32'hed8ff212);
    load_word(2'd3, 32'hef0bc156);

    for (int i = 0; i < 5; i++)
      run_cmd(1'b0, vecs[i], 2, 1'b0, 1'b0, 2'd0, 32'h0, $sformatf("vec%0d", i));

    // Writes attempted throughout a command must not disturb the buffer.
    run_cmd(1'b0, mk(5'd1, 3'd4, 5, 32'h80000001, 32'he0318a99, 32'h23f247b3, 32'hed8ff212, 32'hef0bc156),
            2, 1'b1, 1'b0, 2'd0, 32'h0, "busyload");
    run_cmd(1'b0, mk(5'h11, 3'd4, 5, 32'h80000011, 32'he0318a99, 32'h23f247b3, 32'hed8ff212, 32'hef0bc156),
            2, 1'b0, 1'b0, 2'd0, 32'h0, "afterload");

    // Load and acceptance on the same edge: payload sees the new word.
    run_cmd(1'b0, mk(5'd2, 3'd1, 2, 32'h80000002, 32'h12345678, 32'h0, 32'h0, 32'h0),
            2, 1'b0, 1'b1, 2'd0, 32'h12345678, "sameedge");

    // Reset during the second payload word aborts with no done pulse.
    opcode = 5'd9; len = 3'd4; cv0 = 1'b1;
    tick();
    cv0 = 1'b0;
    check("abort hdr", instr0, 32'h80000009);
    tick();
    tick();
    check("abort w0", instr0, 32'h12345678);
    tick();
    tick();
    check("abort w1", instr0, 32'h23f247b3);
    #2 resetN = 1'b0;
    #1;
    check("abort instr", instr0, 32'h0);
    check("abort busy", 32'(busy0), 32'd0);
    check("abort ready", 32'(ready0), 32'd1);
    check("abort done", 32'(done0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort hold done %0d", i), 32'(done0), 32'd0);
    end
    resetN = 1'b1;
    run_cmd(1'b0, mk(5'ha, 3'd1, 2, 32'h8000000a, 32'h0, 32'h0, 32'h0, 32'h0),
            2, 1'b0, 1'b0, 2'd0, 32'h0, "cleared");

    // Back-to-back with cmdValid held: second header two cycles after done.
    opcode = 5'd4; len = 3'd0; cv0 = 1'b1;
    tick();
    opcode = 5'd5;
    check("b2b h1a", instr0, 32'h80000004);
    tick();
    check("b2b h1b", instr0, 32'h80000004);
    tick();
    check("b2b done1", 32'(done0), 32'd1);
    tick();
    check("b2b idle ready", 32'(ready0), 32'd1);
    check("b2b idle instr", instr0, 32'h0);
    tick();
    cv0 = 1'b0;
    check("b2b h2a", instr0, 32'h80000005);
    tick();
    check("b2b h2b", instr0, 32'h80000005);
    tick();
    check("b2b done2", 32'(done0), 32'd1);
    tick();
    check("b2b end busy", 32'(busy0), 32'd0);

    // Single-cycle words on the HOLD_CYCLES=1 instance.
    load_word(2'd0, 32'he0318a99);
    load_word(2'd1, 32'h23f247b3);
    load_word(2'd2, 32'hed8ff212);
    load_word(2'd3, 32'hef0bc156);
    run_cmd(1'b1, vecs[0], 1, 1'b0, 1'b0, 2'd0, 32'h0, "hold1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
